// File: rtl/bus_read_driver.sv
// bus_read_driver: source side of the shared data bus.
// Takes a read request from the control unit, fetches either one register
// source (single-cycle) or a data-memory word (Mem_en/Mem_ready handshake
// guarded by a timeout), then presents the value on BusOut with a one-cycle
// Bus_valid strobe. Bad register selects and memory timeouts raise a
// one-cycle Err strobe instead. Every output comes straight from a flop.
module bus_read_driver #(
  parameter int WIDTH   = 8,
  parameter int NSRC    = 8,
  parameter int SELW    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                  Clk,
  input  logic                  RST,
  input  logic                  Rd_req,
  input  logic                  Rd_mem,
  input  logic [SELW-1:0]       Rd_sel,
  input  logic [NSRC*WIDTH-1:0] Src_data,
  input  logic [WIDTH-1:0]      Mem_rdata,
  input  logic                  Mem_ready,
  output logic                  Mem_en,
  output logic [WIDTH-1:0]      BusOut,
  output logic                  Bus_valid,
  output logic                  Busy,
  output logic                  Err
);

  // Timeout counter is 8 bits wide, enough for TIMEOUT up to 255. The abort
  // fires on the edge where the count already equals TIMEOUT-1, so Mem_en
  // stays high for exactly TIMEOUT cycles when Mem_ready never arrives.
  localparam int          CNTW    = 8;
  localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRIVE    = 2'd2
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  bus_q;
  logic              bus_valid_q;
  logic              mem_en_q;
  logic              busy_q;
  logic              err_q;
  logic [CNTW-1:0]   cnt_q;

  logic [WIDTH-1:0]  src_word_d;
  logic              sel_ok_d;
  logic [CNTW-1:0]   cnt_d;
  logic              timeout_d;

  // Register-source mux: selects the addressed slice and flags out-of-range selects.
  always_comb begin
    src_word_d = {WIDTH{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (Rd_sel == SELW'(i)) begin
        src_word_d = Src_data[i*WIDTH +: WIDTH];
      end else begin
        src_word_d = src_word_d;
      end
    end
    sel_ok_d = (32'(Rd_sel) < 32'(NSRC));
  end

  // Timeout bookkeeping: next count value and the "last allowed cycle" flag.
  always_comb begin
    cnt_d     = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    timeout_d = (cnt_q == TO_LAST);
  end

  // Read FSM with registered bus, strobe, handshake and status outputs.
  always_ff @(posedge Clk) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      bus_q       <= {WIDTH{1'b0}};
      bus_valid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= {CNTW{1'b0}};
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      bus_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Rd_req) begin
            if (Rd_mem) begin
              // Memory read: Rd_sel is irrelevant here.
              mem_en_q <= 1'b1;
              cnt_q    <= {CNTW{1'b0}};
              busy_q   <= 1'b1;
              state_q  <= ST_MEM_WAIT;
            end else if (sel_ok_d) begin
              // Register read: Src_data is captured only on this edge.
              bus_q       <= src_word_d;
              bus_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= ST_DRIVE;
            end else begin
              // Nonexistent source: flag it, leave the bus alone.
              err_q <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MEM_WAIT: begin
          if (Mem_ready) begin
            // Ready beats a coincident timeout.
            bus_q       <= Mem_rdata;
            bus_valid_q <= 1'b1;
            mem_en_q    <= 1'b0;
            state_q     <= ST_DRIVE;
          end else if (timeout_d) begin
            bus_q    <= {WIDTH{1'b0}};
            mem_en_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DRIVE: begin
          // Bus_valid was raised on entry; requests here are not accepted.
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_en_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign BusOut    = bus_q;
  assign Bus_valid = bus_valid_q;
  assign Mem_en    = mem_en_q;
  assign Busy      = busy_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_bus_read_driver.sv
// Directed bench for bus_read_driver (instance built with NSRC=6 so that
// out-of-range register selects can be exercised with a 3-bit Rd_sel).
module tb_bus_read_driver;

  localparam int WIDTH   = 8;
  localparam int NSRC    = 6;
  localparam int SELW    = 3;
  localparam int TIMEOUT = 15;

  logic                  Clk = 1'b0;
  logic                  RST;
  logic                  Rd_req;
  logic                  Rd_mem;
  logic [SELW-1:0]       Rd_sel;
  logic [NSRC*WIDTH-1:0] Src_data;
  logic [WIDTH-1:0]      Mem_rdata;
  logic                  Mem_ready;
  logic                  Mem_en;
  logic [WIDTH-1:0]      BusOut;
  logic                  Bus_valid;
  logic                  Busy;
  logic                  Err;

  int checks = 0;
  int errors = 0;

  bus_read_driver #(
    .WIDTH  (WIDTH),
    .NSRC   (NSRC),
    .SELW   (SELW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk      (Clk),
    .RST      (RST),
    .Rd_req   (Rd_req),
    .Rd_mem   (Rd_mem),
    .Rd_sel   (Rd_sel),
    .Src_data (Src_data),
    .Mem_rdata(Mem_rdata),
    .Mem_ready(Mem_ready),
    .Mem_en   (Mem_en),
    .BusOut   (BusOut),
    .Bus_valid(Bus_valid),
    .Busy     (Busy),
    .Err      (Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_slice(input int idx, input logic [7:0] val);
    Src_data[idx*WIDTH +: WIDTH] = val;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] bus, input logic vld,
                         input logic men, input logic bsy, input logic err);
    chk({tag, ".bus"},  BusOut,    bus);
    chk({tag, ".vld"},  {7'd0, Bus_valid}, {7'd0, vld});
    chk({tag, ".men"},  {7'd0, Mem_en},    {7'd0, men});
    chk({tag, ".busy"}, {7'd0, Busy},      {7'd0, bsy});
    chk({tag, ".err"},  {7'd0, Err},       {7'd0, err});
  endtask

  initial begin
    RST       = 1'b0;
    Rd_req    = 1'b1;
    Rd_mem    = 1'b0;
    Rd_sel    = 3'd3;
    Src_data  = '0;
    Mem_rdata = 8'd0;
    Mem_ready = 1'b0;
    for (int i = 0; i < NSRC; i++) set_slice(i, 8'(8'h10 + i));
    set_slice(3, 8'd12);
    set_slice(5, 8'h5A);

    // T1: reset held two edges with a pending request.
    tick();
    tick();
    chk_all("t1_reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    Rd_req = 1'b0;
    RST    = 1'b1;
    tick();
    chk_all("t1_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T2: register read of slice 3; later Src_data change must not leak.
    Rd_sel = 3'd3; Rd_mem = 1'b0; Rd_req = 1'b1;
    tick();
    chk_all("t2_drive", 8'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    Rd_req = 1'b0;
    set_slice(3, 8'd99);
    tick();
    chk_all("t2_after", 8'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_hold", BusOut, 8'd12);

    // T3: memory read, ready on the third wait edge.
    Rd_mem = 1'b1; Rd_sel = 3'd7; Rd_req = 1'b1;
    tick();
    chk_all("t3_w0", 8'd12, 1'b0, 1'b1, 1'b1, 1'b0);
    Rd_req = 1'b0;
    tick();
    chk_all("t3_w1", 8'd12, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("t3_w2", 8'd12, 1'b0, 1'b1, 1'b1, 1'b0);
    Mem_ready = 1'b1; Mem_rdata = 8'd34;
    tick();
    chk_all("t3_drive", 8'd34, 1'b1, 1'b0, 1'b1, 1'b0);
    Mem_ready = 1'b0;
    tick();
    chk_all("t3_after", 8'd34, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mem_ready outside MEM_WAIT is ignored.
    Mem_ready = 1'b1; Mem_rdata = 8'h77;
    tick();
    chk_all("stray_rdy", 8'd34, 1'b0, 1'b0, 1'b0, 1'b0);
    Mem_ready = 1'b0;

    // T4: timeout. Mem_en high TIMEOUT cycles, then Err and BusOut=0.
    Rd_mem = 1'b1; Rd_req = 1'b1;
    tick();
    chk_all("t4_w0", 8'd34, 1'b0, 1'b1, 1'b1, 1'b0);
    Rd_req = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      chk("t4_wait_men", {7'd0, Mem_en}, 8'd1);
      chk("t4_wait_err", {7'd0, Err},    8'd0);
    end
    tick();
    chk_all("t4_abort", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("t4_after", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Ready arriving on the timeout edge wins.
    Rd_mem = 1'b1; Rd_req = 1'b1;
    tick();
    Rd_req = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) tick();
    chk("race_men_pre", {7'd0, Mem_en}, 8'd1);
    Mem_ready = 1'b1; Mem_rdata = 8'hA5;
    tick();
    chk_all("race_drive", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    Mem_ready = 1'b0;
    tick();
    chk_all("race_after", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // T5: bad selects 7 and 6 (NSRC=6), then valid select 5.
    Rd_mem = 1'b0; Rd_sel = 3'd7; Rd_req = 1'b1;
    tick();
    chk_all("t5_bad7", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    Rd_sel = 3'd6;
    tick();
    chk_all("t5_bad6", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    Rd_sel = 3'd5;
    tick();
    chk_all("t5_good5", 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    Rd_req = 1'b0;
    tick();
    chk_all("t5_after", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    // T6a: reset during MEM_WAIT.
    Rd_mem = 1'b1; Rd_req = 1'b1;
    tick();
    chk("t6a_men", {7'd0, Mem_en}, 8'd1);
    Rd_req = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    chk_all("t6a_reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    tick();
    chk_all("t6a_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T6b: Rd_req held through DRIVE; second read only accepted from IDLE.
    Rd_mem = 1'b0; Rd_sel = 3'd3; Rd_req = 1'b1;
    tick();
    chk_all("t6b_rd1", 8'd99, 1'b1, 1'b0, 1'b1, 1'b0);
    Rd_sel = 3'd5;
    tick();
    chk_all("t6b_gap", 8'd99, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("t6b_rd2", 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    Rd_req = 1'b0;
    tick();
    chk_all("t6b_end", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
